// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_e;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants won while a fetch was waiting.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned CW = cnt_width(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// data first, with a starvation limit that forces fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LW = cnt_width(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [LW-1:0]     lat_q, lat_d;

  logic starve_inc, starve_clr, starve_at_max;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    lat_d      = lat_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
          if (d_req && !(if_req && starve_at_max)) begin
            owner_d    = DATA;
            addr_d     = d_addr;
            we_d       = d_we;
            wdata_d    = d_wdata;
            starve_inc = if_req;
          end else begin
            owner_d    = FETCH;
            addr_d     = if_addr;
            we_d       = 1'b0;
            starve_clr = 1'b1;
          end
          lat_d   = LW'(MEM_LAT - 1);
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (lat_q == '0) begin
          if (owner_q == FETCH) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      lat_q      <= lat_d;
    end
  end

  // Every output decodes registered state only; no request reaches an output combinationally.
  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && (owner_q == DATA) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = (state_q == RESP) && (owner_q == FETCH);
  assign d_done    = (state_q == RESP) && (owner_q == DATA);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: MEM_LAT=2/STARVE_MAX=3 main instance, MEM_LAT=1 boundary instance.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic clk = 1'b0;
  logic rst;

  logic        if_req, if_done, d_req, d_we, d_done, mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_if_req, b_if_done, b_d_req, b_d_we, b_d_done, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned b_en_cnt = 0;
  int unsigned t0;
  logic [31:0] last_d;

  exp_t        sbq[$];
  exp_t        sbq_b[$];
  logic [31:0] fq[$];
  logic [31:0] fq_b[$];
  dreq_t       dq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata   = memval(mem_addr);
  assign b_mem_rdata = memval(b_mem_addr);

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (1),
    .STARVE_MAX (4)
  ) u_dut_lat1 (
    .clk       (clk),
    .rst       (rst),
    .if_req    (b_if_req),
    .if_addr   (b_if_addr),
    .if_done   (b_if_done),
    .if_rdata  (b_if_rdata),
    .d_req     (b_d_req),
    .d_we      (b_d_we),
    .d_addr    (b_d_addr),
    .d_wdata   (b_d_wdata),
    .d_done    (b_d_done),
    .d_rdata   (b_d_rdata),
    .mem_en    (b_mem_en),
    .mem_we    (b_mem_we),
    .mem_addr  (b_mem_addr),
    .mem_wdata (b_mem_wdata),
    .mem_rdata (b_mem_rdata),
    .busy      (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv_fetch();
    if (fq.size() > 0) begin
      if_addr = fq.pop_front();
      if_req  = 1'b1;
    end else begin
      if_req = 1'b0;
    end
  endtask

  task automatic adv_data();
    dreq_t r;
    if (dq.size() > 0) begin
      r       = dq.pop_front();
      d_we    = r.we;
      d_addr  = r.addr;
      d_wdata = r.wdata;
      d_req   = 1'b1;
    end else begin
      d_req = 1'b0;
    end
  endtask

  task automatic step_a();
    exp_t e;
    tick();
    if (if_done || d_done) begin
      chk("single_done", {31'd0, if_done & d_done}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", {31'd0, if_done | d_done}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("done_owner", {31'd0, d_done}, {31'd0, e.is_data});
        chk("done_cycle", cyc, e.cyc);
        if (d_done) begin
          chk("d_rdata", d_rdata, e.rdata);
          adv_data();
        end else begin
          chk("if_rdata", if_rdata, e.rdata);
          adv_fetch();
        end
      end
    end
    if (mem_we) chk("we_needs_en", {31'd0, mem_en}, 32'd1);
  endtask

  task automatic drain_a(input int unsigned budget);
    int unsigned n = 0;
    while (sbq.size() > 0 && n < budget) begin
      step_a();
      n++;
    end
    chk("drain_a", sbq.size(), 32'd0);
  endtask

  task automatic step_b();
    exp_t e;
    tick();
    if (b_mem_en) b_en_cnt++;
    if (b_if_done || b_d_done) begin
      if (sbq_b.size() == 0) begin
        chk("b_unexpected_done", {31'd0, b_if_done | b_d_done}, 32'd0);
      end else begin
        e = sbq_b.pop_front();
        chk("b_done_owner", {31'd0, b_d_done}, {31'd0, e.is_data});
        chk("b_done_cycle", cyc, e.cyc);
        chk("b_if_rdata", b_if_rdata, e.rdata);
        if (fq_b.size() > 0) b_if_addr = fq_b.pop_front();
        else b_if_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    last_d = '0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_dones", {30'd0, if_done, d_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch only at 0x40
    fq.push_back(32'h40);
    adv_fetch();
    t0 = cyc + 1;
    sbq.push_back('{is_data: 1'b0, rdata: 32'h2008_0005, cyc: t0 + 2});
    step_a();
    chk("f_en0", {31'd0, mem_en}, 32'd1);
    chk("f_addr0", mem_addr, 32'h40);
    chk("f_we0", {31'd0, mem_we}, 32'd0);
    chk("f_busy", {31'd0, busy}, 32'd1);
    step_a();
    chk("f_en1", {31'd0, mem_en}, 32'd1);
    chk("f_we1", {31'd0, mem_we}, 32'd0);
    step_a();
    chk("f_en_resp", {31'd0, mem_en}, 32'd0);
    drain_a(10);
    step_a();
    step_a();
    chk("idle_addr_hold", mem_addr, 32'h40);

    // Simultaneous fetch and load: data first
    fq.push_back(32'h44);
    dq.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    adv_fetch();
    adv_data();
    t0 = cyc + 1;
    sbq.push_back('{is_data: 1'b1, rdata: memval(32'h100), cyc: t0 + 2});
    sbq.push_back('{is_data: 1'b0, rdata: memval(32'h44), cyc: t0 + 6});
    last_d = memval(32'h100);
    drain_a(20);
    step_a();
    step_a();

    // Starvation: STARVE_MAX=3 data wins, then fetch; counter clears so data wins again
    fq.push_back(32'h80);
    fq.push_back(32'h84);
    for (int i = 0; i < 4; i++) dq.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    adv_fetch();
    adv_data();
    t0 = cyc + 1;
    sbq.push_back('{is_data: 1'b1, rdata: memval(32'h300), cyc: t0 + 2});
    sbq.push_back('{is_data: 1'b1, rdata: memval(32'h300), cyc: t0 + 6});
    sbq.push_back('{is_data: 1'b1, rdata: memval(32'h300), cyc: t0 + 10});
    sbq.push_back('{is_data: 1'b0, rdata: memval(32'h80),  cyc: t0 + 14});
    sbq.push_back('{is_data: 1'b1, rdata: memval(32'h300), cyc: t0 + 18});
    sbq.push_back('{is_data: 1'b0, rdata: memval(32'h84),  cyc: t0 + 22});
    last_d = memval(32'h300);
    drain_a(40);
    step_a();
    step_a();

    // Store: d_rdata keeps the previous load value
    dq.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF});
    adv_data();
    t0 = cyc + 1;
    sbq.push_back('{is_data: 1'b1, rdata: last_d, cyc: t0 + 2});
    step_a();
    chk("st_en0", {31'd0, mem_en}, 32'd1);
    chk("st_we0", {31'd0, mem_we}, 32'd1);
    chk("st_addr0", mem_addr, 32'h200);
    chk("st_wdata0", mem_wdata, 32'hDEAD_BEEF);
    step_a();
    chk("st_we1", {31'd0, mem_we}, 32'd1);
    chk("st_addr1", mem_addr, 32'h200);
    step_a();
    chk("st_we_resp", {31'd0, mem_we}, 32'd0);
    drain_a(10);
    step_a();
    chk("st_wdata_hold", mem_wdata, 32'hDEAD_BEEF);

    // Reset in the first ACCESS cycle: abandoned, then serviced after release
    fq.push_back(32'h48);
    adv_fetch();
    step_a();
    chk("ra_en", {31'd0, mem_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ra_busy", {31'd0, busy}, 32'd0);
    chk("ra_mem_en", {31'd0, mem_en}, 32'd0);
    chk("ra_mem_addr", mem_addr, 32'd0);
    chk("ra_if_rdata", if_rdata, 32'd0);
    chk("ra_d_rdata", d_rdata, 32'd0);
    step_a();
    chk("ra_hold_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    t0 = cyc + 1;
    sbq.push_back('{is_data: 1'b0, rdata: memval(32'h48), cyc: t0 + 2});
    drain_a(10);
    step_a();
    chk("ra_d_rdata_after", d_rdata, 32'd0);

    // MEM_LAT=1 back-to-back fetches
    fq_b.push_back(32'h14);
    fq_b.push_back(32'h18);
    b_if_addr = 32'h10;
    b_if_req  = 1'b1;
    b_en_cnt  = 0;
    t0 = cyc + 1;
    sbq_b.push_back('{is_data: 1'b0, rdata: memval(32'h10), cyc: t0 + 1});
    sbq_b.push_back('{is_data: 1'b0, rdata: memval(32'h14), cyc: t0 + 4});
    sbq_b.push_back('{is_data: 1'b0, rdata: memval(32'h18), cyc: t0 + 7});
    for (int n = 0; n < 20 && sbq_b.size() > 0; n++) step_b();
    chk("b_drain", sbq_b.size(), 32'd0);
    step_b();
    step_b();
    chk("b_en_cycles", b_en_cnt, 32'd3);
    chk("b_idle", {31'd0, b_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
